// File: rtl/flght_pkg.sv
// flght_pkg: shared types and defaults for the flight-mode sequencer.
//   flt_state_t : sequencer state encoding (also exported on the debug port)
//   THRST_W     : thrust datapath width
//   *_DEF       : default parameter values for flght_seq
package flght_pkg;

  localparam int THRST_W        = 9;
  localparam int CAL_VLDS_DEF   = 256;
  localparam int FILL_VLDS_DEF  = 14;
  localparam int RAMP_STEP_DEF  = 4;
  localparam int TMO_CYCLES_DEF = 2_500_000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CAL    = 3'd1,
    SETTLE = 3'd2,
    FLY    = 3'd3,
    LAND   = 3'd4
  } flt_state_t;

endpackage

// File: rtl/flght_seq_thrst_ramp.sv
// thrst_ramp: registered slew limiter for the thrust fed to the datapath.
//   clk, rst_n     : clock, async active-low reset
//   target         : requested thrust
//   step_en        : move one step towards the target this cycle
//   force_zero_tgt : ignore target and ramp towards zero (landing)
//   clr            : synchronous clear to zero
//   thrst          : slew-limited thrust
module thrst_ramp
  import flght_pkg::*;
#(
  parameter int RAMP_STEP = RAMP_STEP_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [THRST_W-1:0] target,
  input  logic               step_en,
  input  logic               force_zero_tgt,
  input  logic               clr,
  output logic [THRST_W-1:0] thrst
);

  localparam logic [THRST_W:0] STEP_W = (THRST_W + 1)'(RAMP_STEP);

  logic [THRST_W-1:0] thrst_q, thrst_d;
  // one extra bit so thrst+step and target+step never wrap
  logic [THRST_W:0]   cur_w, tgt_w, up_w;
  logic [THRST_W-1:0] dn_w;

  always_comb begin
    tgt_w   = force_zero_tgt ? '0 : {1'b0, target};
    cur_w   = {1'b0, thrst_q};
    up_w    = cur_w + STEP_W;
    dn_w    = thrst_q - STEP_W[THRST_W-1:0];
    thrst_d = thrst_q;
    if (clr) begin
      thrst_d = '0;
    end else if (step_en) begin
      if (cur_w < tgt_w) begin
        thrst_d = (up_w >= tgt_w) ? tgt_w[THRST_W-1:0] : up_w[THRST_W-1:0];
      end else if (cur_w > tgt_w) begin
        // dn_w only taken when thrst exceeds target by more than a step
        thrst_d = (cur_w > tgt_w + STEP_W) ? dn_w : tgt_w[THRST_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) thrst_q <= '0;
    else        thrst_q <= thrst_d;
  end

  assign thrst = thrst_q;

endmodule

// File: rtl/flght_seq.sv
// flght_seq: flight-mode sequencer. Steps the PD datapath through arming,
// inertial calibration, D-queue fill, flight and controlled landing, with a
// comm-loss watchdog that forces a landing.
//   clk, rst_n          : clock, async active-low reset
//   arm, disarm         : single-cycle mode requests (disarm wins)
//   cmd_rdy             : new command received, kicks the watchdog
//   thrst_cmd           : requested thrust
//   vld_in              : inertial reading strobe
//   inertial_cal        : motors at calibration speed
//   vld_out             : vld_in qualified by state
//   thrst               : slew-limited thrust
//   motors_en, tmo_flt  : motor enable, sticky comm-loss fault
//   state               : current state, debug
//
// state  | meaning
// IDLE   | motors off, waiting for arm
// CAL    | inertial calibration, counting CAL_VLDS strobes
// SETTLE | filling the datapath D queue, counting FILL_VLDS strobes
// FLY    | thrust tracks thrst_cmd, watchdog running
// LAND   | ramp thrust to zero, then IDLE
module flght_seq
  import flght_pkg::*;
#(
  parameter int CAL_VLDS   = CAL_VLDS_DEF,
  parameter int FILL_VLDS  = FILL_VLDS_DEF,
  parameter int RAMP_STEP  = RAMP_STEP_DEF,
  parameter int TMO_CYCLES = TMO_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               arm,
  input  logic               disarm,
  input  logic               cmd_rdy,
  input  logic [THRST_W-1:0] thrst_cmd,
  input  logic               vld_in,
  output logic               inertial_cal,
  output logic               vld_out,
  output logic [THRST_W-1:0] thrst,
  output logic               motors_en,
  output logic               tmo_flt,
  output logic [2:0]         state
);

  localparam int CNT_MAX = (CAL_VLDS > FILL_VLDS) ? CAL_VLDS : FILL_VLDS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int WD_W    = $clog2(TMO_CYCLES);

  flt_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             tmo_q, tmo_d;
  logic             wd_term;
  logic             in_air;

  assign wd_term = (wd_q == WD_W'(TMO_CYCLES - 1));
  assign in_air  = (state_q == FLY) || (state_q == LAND);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wd_q    <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wd_d    = wd_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      IDLE: begin
        if (arm && !disarm) begin
          state_d = CAL;
          cnt_d   = '0;
          tmo_d   = 1'b0;
        end
      end
      CAL: begin
        if (disarm) begin
          state_d = IDLE;
        end else if (vld_in) begin
          if (cnt_q == CNT_W'(CAL_VLDS - 1)) begin
            state_d = SETTLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      SETTLE: begin
        if (disarm) begin
          state_d = IDLE;
        end else if (vld_in) begin
          if (cnt_q == CNT_W'(FILL_VLDS - 1)) begin
            state_d = FLY;
            wd_d    = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      FLY: begin
        wd_d = cmd_rdy ? '0 : wd_q + 1'b1;
        if (disarm) begin
          state_d = LAND;
        end else if (wd_term && !cmd_rdy) begin
          state_d = LAND;
          tmo_d   = 1'b1;
        end
      end
      LAND: begin
        if (thrst == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    motors_en    = (state_q != IDLE);
    inertial_cal = (state_q == CAL);
    vld_out      = vld_in && ((state_q == SETTLE) || in_air);
  end

  thrst_ramp #(
    .RAMP_STEP(RAMP_STEP)
  ) u_ramp (
    .clk           (clk),
    .rst_n         (rst_n),
    .target        (thrst_cmd),
    .step_en       (vld_in && in_air),
    .force_zero_tgt(state_q == LAND),
    .clr           (!in_air),
    .thrst         (thrst)
  );

  assign tmo_flt = tmo_q;
  assign state   = state_q;

endmodule

// File: tb/tb_flght_seq.sv
module tb_flght_seq;

  localparam int CAL  = 4;
  localparam int FILL = 3;
  localparam int STEP = 4;
  localparam int TMO  = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       arm = 1'b0, disarm = 1'b0, cmd_rdy = 1'b0, vld_in = 1'b0;
  logic [8:0] thrst_cmd = '0;
  logic       inertial_cal, vld_out, motors_en, tmo_flt;
  logic [8:0] thrst;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  int up_exp[4]   = '{4, 8, 10, 10};
  int dn_exp[3]   = '{6, 2, 1};
  int land_exp[3] = '{5, 1, 0};

  flght_seq #(
    .CAL_VLDS  (CAL),
    .FILL_VLDS (FILL),
    .RAMP_STEP (STEP),
    .TMO_CYCLES(TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .arm         (arm),
    .disarm      (disarm),
    .cmd_rdy     (cmd_rdy),
    .thrst_cmd   (thrst_cmd),
    .vld_in      (vld_in),
    .inertial_cal(inertial_cal),
    .vld_out     (vld_out),
    .thrst       (thrst),
    .motors_en   (motors_en),
    .tmo_flt     (tmo_flt),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: mode numbers follow the documented state encoding.
  int m_mode = 0, m_cnt = 0, m_wd = 0, m_thr = 0, m_tmo = 0;

  function automatic int slew(input int cur, input int tgt);
    if (cur < tgt) return (cur + STEP < tgt) ? cur + STEP : tgt;
    if (cur > tgt) return (cur - STEP > tgt) ? cur - STEP : tgt;
    return cur;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int nm, nc, nw, nt, nf;
    if (!rst_n) begin
      m_mode <= 0; m_cnt <= 0; m_wd <= 0; m_thr <= 0; m_tmo <= 0;
    end else begin
      nm = m_mode; nc = m_cnt; nw = m_wd; nt = m_thr; nf = m_tmo;
      case (m_mode)
        0: if (arm && !disarm) begin nm = 1; nc = 0; nf = 0; end
        1: if (disarm) nm = 0;
           else if (vld_in) begin
             nc = m_cnt + 1;
             if (nc == CAL) begin nm = 2; nc = 0; end
           end
        2: if (disarm) nm = 0;
           else if (vld_in) begin
             nc = m_cnt + 1;
             if (nc == FILL) begin nm = 3; nw = 0; end
           end
        3: begin
          if (vld_in) nt = slew(m_thr, int'(thrst_cmd));
          if (disarm) nm = 4;
          else if (!cmd_rdy && m_wd == TMO - 1) begin nm = 4; nf = 1; end
          nw = cmd_rdy ? 0 : m_wd + 1;
        end
        4: if (m_thr == 0) nm = 0;
           else if (vld_in) nt = (m_thr <= STEP) ? 0 : m_thr - STEP;
        default: nm = 0;
      endcase
      m_mode <= nm; m_cnt <= nc; m_wd <= nw; m_thr <= nt; m_tmo <= nf;
    end
  end

  always @(negedge clk) begin
    chk("state", 32'(state), m_mode);
    chk("thrst", 32'(thrst), m_thr);
    chk("motors_en", 32'(motors_en), (m_mode != 0) ? 1 : 0);
    chk("inertial_cal", 32'(inertial_cal), (m_mode == 1) ? 1 : 0);
    chk("tmo_flt", 32'(tmo_flt), m_tmo);
    chk("vld_out", 32'(vld_out), (vld_in && m_mode >= 2) ? 1 : 0);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic strobe(input logic kick);
    vld_in = 1'b1; cmd_rdy = kick;
    cyc();
    vld_in = 1'b0; cmd_rdy = 1'b0;
  endtask

  task automatic arm_pulse();
    arm = 1'b1; cyc(); arm = 1'b0;
  endtask

  initial begin
    int cal_cnt = 0;
    int first_vo = 0;

    // reset
    idle(3);
    chk("rst_state", 32'(state), 0);
    chk("rst_thrst", 32'(thrst), 0);
    chk("rst_motors", 32'(motors_en), 0);
    rst_n = 1'b1;
    idle(2);

    // arm, calibrate, fill
    arm_pulse();
    chk("cal_entry", 32'(inertial_cal), 1);
    for (int s = 1; s <= 7; s++) begin
      idle(3);
      vld_in = 1'b1;
      #1;
      if (inertial_cal) cal_cnt++;
      if (vld_out && first_vo == 0) first_vo = s;
      if (s == 7) chk("pre_fly", 32'(state), 2);
      cyc();
      vld_in = 1'b0;
    end
    chk("cal_strobes", 32'(cal_cnt), 4);
    chk("first_vld_out", 32'(first_vo), 5);
    chk("fly_entry", 32'(state), 3);

    // ramp up then down
    thrst_cmd = 9'd10;
    for (int i = 0; i < 4; i++) begin
      idle(2); strobe(1'b1);
      chk("ramp_up", 32'(thrst), up_exp[i]);
    end
    thrst_cmd = 9'd1;
    for (int i = 0; i < 3; i++) begin
      idle(2); strobe(1'b1);
      chk("ramp_dn", 32'(thrst), dn_exp[i]);
    end

    // reach 9, then comm loss
    thrst_cmd = 9'd9;
    idle(2); strobe(1'b1);
    idle(2); strobe(1'b1);
    chk("thrst_9", 32'(thrst), 9);
    idle(99);
    chk("wd_pre_tmo", 32'(state), 3);
    cyc();
    chk("tmo_land", 32'(state), 4);
    chk("tmo_flt_set", 32'(tmo_flt), 1);
    for (int i = 0; i < 3; i++) begin
      idle(3); strobe(1'b0);
      chk("land_ramp", 32'(thrst), land_exp[i]);
    end
    chk("land_hold", 32'(state), 4);
    cyc();
    chk("land_idle", 32'(state), 0);
    idle(5);
    chk("tmo_sticky", 32'(tmo_flt), 1);

    // kick on the terminal-count cycle
    arm_pulse();
    chk("tmo_clr_arm", 32'(tmo_flt), 0);
    for (int i = 0; i < 7; i++) strobe(1'b0);
    chk("fly2", 32'(state), 3);
    idle(99);
    cmd_rdy = 1'b1; cyc(); cmd_rdy = 1'b0;
    chk("kick_term_state", 32'(state), 3);
    chk("kick_term_tmo", 32'(tmo_flt), 0);

    // disarm paths and arm/disarm priority
    disarm = 1'b1; cyc(); disarm = 1'b0;
    chk("disarm_fly", 32'(state), 4);
    cyc();
    chk("land_zero_idle", 32'(state), 0);
    arm = 1'b1; disarm = 1'b1; cyc(); arm = 1'b0; disarm = 1'b0;
    chk("arm_disarm", 32'(state), 0);
    arm_pulse();
    chk("rearm", 32'(state), 1);
    disarm = 1'b1; cyc(); disarm = 1'b0;
    chk("disarm_cal", 32'(state), 0);
    chk("disarm_cal_ic", 32'(inertial_cal), 0);
    arm_pulse();
    for (int i = 0; i < 3; i++) strobe(1'b0);
    vld_in = 1'b1; disarm = 1'b1; cyc(); vld_in = 1'b0; disarm = 1'b0;
    chk("disarm_last_cal", 32'(state), 0);

    // reset mid-flight at thrust 200
    arm_pulse();
    for (int i = 0; i < 7; i++) strobe(1'b0);
    thrst_cmd = 9'd200;
    for (int i = 0; i < 50; i++) strobe(1'b1);
    chk("thrst_200", 32'(thrst), 200);
    arm_pulse();
    chk("arm_in_fly", 32'(state), 3);
    #2;
    vld_in = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_fly_state", 32'(state), 0);
    chk("rst_fly_thrst", 32'(thrst), 0);
    chk("rst_fly_motors", 32'(motors_en), 0);
    chk("rst_fly_vld_out", 32'(vld_out), 0);
    idle(2);
    vld_in = 1'b0;
    rst_n = 1'b1;
    idle(1);
    arm_pulse();
    chk("rst_rearm", 32'(state), 1);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/flght_seq.md
# flght_seq

Flight-mode sequencer for the flight controller. It sequences the motor-speed PD datapath through arming, inertial calibration, derivative-queue fill, flight, and controlled landing. It owns `inertial_cal`, the qualified inertial `vld` strobe and the slew-limited `thrst` fed into the datapath. It sits between the command configuration logic (arm/disarm/thrust commands) and the flight control datapath, and adds a comm-loss watchdog that forces a landing.

## Interface
Parameters:
- `CAL_VLDS`, default 256: number of `vld_in` strobes spent in calibration.
- `FILL_VLDS`, default 14: number of `vld_in` strobes needed to fill the datapath D queue. Must equal the datapath `D_QUEUE_DEPTH`.
- `RAMP_STEP`, default 4: maximum `thrst` change per `vld_in` strobe, range 1..511.
- `TMO_CYCLES`, default 2_500_000: clock cycles allowed without `cmd_rdy` in FLY before a forced landing.

Ports (reset `rst_n`, asynchronous, active-low; clock `clk`):
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `arm` in 1: single-cycle arm request.
- `disarm` in 1: single-cycle disarm request.
- `cmd_rdy` in 1: single-cycle pulse; a new command was received (watchdog kick).
- `thrst_cmd` in 9: requested thrust, unsigned.
- `vld_in` in 1: new inertial reading strobe.
- `inertial_cal` out 1: drive motors at calibration speed.
- `vld_out` out 1: qualified valid strobe to the datapath.
- `thrst` out 9: slew-limited thrust to the datapath.
- `motors_en` out 1: motor drivers enabled.
- `tmo_flt` out 1: sticky comm-loss fault.
- `state` out 3: current state encoding, for debug.

## Operation
States:
- IDLE: `motors_en`=0, `inertial_cal`=0, `thrst`=0.
  - `arm` -> CAL. Clears the vld counter and `tmo_flt`.
- CAL: `motors_en`=1, `inertial_cal`=1, `thrst`=0.
  - Counts `vld_in` strobes. The strobe that brings the count to `CAL_VLDS` -> SETTLE, with the counter cleared.
  - `disarm` -> IDLE.
- SETTLE: `motors_en`=1, `inertial_cal`=0, `thrst`=0.
  - Counts `vld_in` strobes. The strobe that brings the count to `FILL_VLDS` -> FLY, with the watchdog cleared.
  - `disarm` -> IDLE.
- FLY: `thrst` tracks `thrst_cmd`, applied on each `vld_in`:
  - If `thrst` < `thrst_cmd`: `thrst` = min(`thrst`+`RAMP_STEP`, `thrst_cmd`).
  - If `thrst` > `thrst_cmd`: `thrst` = max(`thrst`−`RAMP_STEP`, `thrst_cmd`).
  - Intermediate arithmetic is 10-bit, so no wrap occurs.
  - The watchdog increments every cycle and clears on `cmd_rdy`.
  - Watchdog reaching `TMO_CYCLES`-1 with no `cmd_rdy` that cycle -> LAND, and `tmo_flt` sets.
  - `disarm` -> LAND.
- LAND: on each `vld_in`, `thrst` = (`thrst` ≤ `RAMP_STEP`) ? 0 : `thrst`−`RAMP_STEP`.
  - `thrst`==0 -> IDLE on the next cycle, with or without `vld_in`.
  - `arm`, `disarm`, `cmd_rdy` and `thrst_cmd` are ignored.
- `vld_out` = `vld_in` while in SETTLE, FLY or LAND; 0 in IDLE and CAL. This keeps calibration-era errors out of the D queue.

Priority and boundary rules:
- `arm` and `disarm` in the same cycle: `disarm` wins (IDLE stays IDLE).
- `arm` outside IDLE is ignored.
- `cmd_rdy` in the same cycle that the watchdog reaches terminal count: the kick wins and there is no landing.
- `disarm` in the same cycle as the final CAL/SETTLE `vld_in`: -> IDLE.
- `tmo_flt` is cleared only by `arm` accepted in IDLE, or by reset.
- Reset asserted mid-flight: immediately IDLE with all outputs at reset values. No landing ramp.

## Timing
- Reset values: `state`=IDLE, `thrst`=0, `inertial_cal`=0, `motors_en`=0, `tmo_flt`=0, all counters 0. `vld_out`=0 because `vld_out` is gated by state.
- `state`, `thrst`, `inertial_cal`, `motors_en` and `tmo_flt` are registered and update on the clock edge after the qualifying input.
- `vld_out` is combinational from `vld_in` and the registered state, with zero latency.
- The `thrst` update takes effect one cycle after `vld_in`, so the datapath sees the new thrust on the following reading.
- From `arm` to the first FLY cycle: 1 cycle, plus the cycles spanning `CAL_VLDS`+`FILL_VLDS` strobes, plus 1.
- Landing from `thrst`=T: ceil(T/`RAMP_STEP`) strobes, plus 1 cycle, to reach IDLE.

## Structure
- Package `flght_pkg` holds:
  - the state enum `flt_state_t` (IDLE=0, CAL=1, SETTLE=2, FLY=3, LAND=4);
  - the default parameter constants;
  - `THRST_W`=9.
- Sub-module `thrst_ramp`: a registered slew limiter.
  - Inputs: `target`, `step_en` (=`vld_in` in FLY/LAND), `force_zero_tgt` (LAND), `clr`.
  - Output: `thrst`.
  - It contains the min/max clamping.
- The FSM, the vld counter and the watchdog counter (width `$clog2(TMO_CYCLES)`) live in the top level.

## Test plan
- Reset with `arm` pulse and `vld_in` every 4 cycles, `CAL_VLDS`=4, `FILL_VLDS`=3:
  - `inertial_cal`=1 for exactly 4 strobes.
  - `vld_out` is first seen on the 5th strobe.
  - FLY entered after the 7th strobe.
- FLY, `thrst`=0, `thrst_cmd`=10, `RAMP_STEP`=4: `thrst` steps 4, 8, 10 on successive strobes, then holds at 10. Then `thrst_cmd`=1 gives 6, 2, 1.
- FLY, `thrst`=9, `TMO_CYCLES`=100, no `cmd_rdy`:
  - After 100 cycles: LAND and `tmo_flt`=1.
  - `thrst` goes 5, 1, 0, then IDLE. `tmo_flt` remains 1 until the next `arm`.
- `cmd_rdy` on the exact terminal-count cycle: remains FLY with `tmo_flt`=0.
- `arm` and `disarm` together in IDLE: stays IDLE. `disarm` during CAL: IDLE with `inertial_cal`=0 next cycle.
- Reset asserted in FLY with `thrst`=200: all outputs 0 and `state`=IDLE while `rst_n` is low. A re-arm restarts at CAL.
